// File: rtl/iic_slave_regif.sv
// ============================================================================
// Module   : iic_slave_regif
// Brief    : I2C target with 16-bit register address, 8-bit data and a
//            single-cycle register-bank port; open-drain SDA, no clock stretch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iic_slave_regif #(
  parameter logic [6:0] DEV_ID   = 7'h2B,
  parameter int         FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out_en,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  localparam logic [2:0] FILT_MAX = 3'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEV  = 3'd1,
    S_AH   = 3'd2,
    S_AL   = 3'd3,
    S_WR   = 3'd4,
    S_RD   = 3'd5
  } state_t;

  logic [1:0] pad;
  logic [1:0] filt;
  assign pad = {sda_in, scl_in};

  // Idle-bus (high) reset levels keep a reset from fabricating START/STOP.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic       s1_q, s2_q, lvl_q;
    logic [2:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q  <= 1'b1;
        s2_q  <= 1'b1;
        lvl_q <= 1'b1;
        cnt_q <= 3'd0;
      end else begin
        s1_q <= pad[gi];
        s2_q <= s1_q;
        if (s2_q == lvl_q) begin
          cnt_q <= 3'd0;
        end else if (cnt_q == FILT_MAX) begin
          lvl_q <= s2_q;
          cnt_q <= 3'd0;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
    end
    assign filt[gi] = lvl_q;
  end

  logic scl_f, sda_f, scl_prev_q, sda_prev_q;
  logic start_w, stop_w, rise_w, fall_w;
  assign scl_f   = filt[0];
  assign sda_f   = filt[1];
  assign start_w = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_w  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign rise_w  = scl_f & ~scl_prev_q;
  assign fall_w  = ~scl_f & scl_prev_q;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic        oe_q, oe_d, busy_q, busy_d, we_q, we_d, re_q, re_d, cap_q, cap_d;
  logic [7:0]  rx_byte;
  assign rx_byte = {shift_q[6:0], sda_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      wdata_q    <= 8'h00;
      addr_q     <= 16'h0000;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cap_q      <= 1'b0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      we_q       <= we_d;
      re_q       <= re_d;
      cap_q      <= cap_d;
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  // cnt: 0..8 bits seen in the byte, 9 = inside the ACK slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    cap_d   = re_q;
    if (cap_q) tx_d = reg_rdata;
    if (we_q) addr_d = addr_q + 16'd1;
    if (start_w) begin
      state_d = S_DEV;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (stop_w) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_AH, S_AL, S_WR: begin
          if (rise_w && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7 && state_q == S_AH) addr_d[15:8] = rx_byte;
            if (cnt_q == 4'd7 && state_q == S_AL) addr_d[7:0]  = rx_byte;
          end else if (rise_w && cnt_q == 4'd9 && state_q == S_DEV && shift_q[0]) begin
            re_d = 1'b1;
          end else if (fall_w && cnt_q == 4'd8) begin
            if (state_q == S_DEV && shift_q[7:1] != DEV_ID) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
              busy_d  = 1'b0;
            end else begin
              oe_d  = 1'b1;
              cnt_d = 4'd9;
              if (state_q == S_DEV) busy_d = 1'b1;
              if (state_q == S_WR) begin
                we_d    = 1'b1;
                wdata_d = shift_q;
              end
            end
          end else if (fall_w && cnt_q == 4'd9) begin
            oe_d  = 1'b0;
            cnt_d = 4'd0;
            case (state_q)
              S_DEV: begin
                if (shift_q[0]) begin
                  state_d = S_RD;
                  oe_d    = ~tx_q[7];
                end else begin
                  state_d = S_AH;
                end
              end
              S_AH:    state_d = S_AL;
              S_AL:    state_d = S_WR;
              default: state_d = state_q;
            endcase
          end
        end
        S_RD: begin
          if (rise_w && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (rise_w && cnt_q == 4'd9) begin
            if (!sda_f) begin
              re_d   = 1'b1;
              addr_d = addr_q + 16'd1;
            end else begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
            end
          end else if (fall_w && cnt_q != 4'd0 && cnt_q < 4'd8) begin
            tx_d = {tx_q[6:0], 1'b0};
            oe_d = ~tx_q[6];
          end else if (fall_w && cnt_q == 4'd8) begin
            oe_d  = 1'b0;
            cnt_d = 4'd9;
          end else if (fall_w && cnt_q == 4'd9) begin
            oe_d  = ~tx_q[7];
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign sda_out_en = oe_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_iic_slave_regif.sv
// ============================================================================
// Module   : tb_iic_slave_regif
// Brief    : Directed bit-banged I2C master bench for iic_slave_regif.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iic_slave_regif;

  logic        clk, rst, scl_m, m_low;
  logic        sda_line, sda_out_en, reg_we, reg_re, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, rdata_q;
  logic [7:0]  bank [0:65535];

  assign sda_line = ~(m_low | sda_out_en);

  iic_slave_regif #(.DEV_ID(7'h2B), .FILT_LEN(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_m),
    .sda_in     (sda_line),
    .sda_out_en (sda_out_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (rdata_q),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered bank: one-cycle read latency.
  always @(posedge clk) if (reg_re) rdata_q <= bank[reg_addr];

  logic [15:0] we_addr[$];
  logic [7:0]  we_data[$];
  logic [15:0] re_addr[$];
  int          oe_cycles = 0;
  logic        both_seen = 1'b0;

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr.push_back(reg_addr);
      we_data.push_back(reg_wdata);
    end
    if (reg_re) re_addr.push_back(reg_addr);
    if (reg_we && reg_re) both_seen = 1'b1;
    if (sda_out_en) oe_cycles++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b1; wait_clk(10);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; wait_clk(10);
    scl_m = 1'b1; wait_clk(10);
    m_low = 1'b1; wait_clk(10);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(10);
    scl_m = 1'b1; wait_clk(10);
    m_low = 1'b0; wait_clk(20);
  endtask

  task automatic clock_bit(output logic smp);
    wait_clk(10); scl_m = 1'b1;
    wait_clk(10); smp = sda_line;
    wait_clk(10); scl_m = 1'b0;
    wait_clk(10);
  endtask

  // gmask bit set: 1-clk SDA inversion in the middle of that bit's SCL-high phase.
  task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i];
      wait_clk(10); scl_m = 1'b1;
      wait_clk(5);
      if (gmask[i]) begin
        m_low = ~m_low; wait_clk(1);
        m_low = ~m_low; wait_clk(14);
      end else begin
        wait_clk(15);
      end
      scl_m = 1'b0; wait_clk(10);
    end
    m_low = 1'b0;
    clock_bit(ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(s);
      d[i] = s;
    end
    m_low = ~ack_bit;
    clock_bit(s);
    m_low = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic        ack, s;
  logic [7:0]  d;
  int          wb, rb, ob;
  logic [15:0] exp_wa [3];
  logic [7:0]  exp_wd [3];
  logic [15:0] exp_ra [3];
  logic [7:0]  exp_rd [3];

  initial begin
    rst = 1'b1; scl_m = 1'b1; m_low = 1'b0;
    wait_clk(3);
    chk("rst_oe",    32'(sda_out_en), 32'h0);
    chk("rst_we",    32'(reg_we),     32'h0);
    chk("rst_re",    32'(reg_re),     32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_addr",  32'(reg_addr),   32'h0);
    chk("rst_wdata", 32'(reg_wdata),  32'h0);
    rst = 1'b0;
    wait_clk(5);

    // Single write 0x1234 <= 0xA5
    wb = we_addr.size();
    i2c_start();
    write_byte(8'h56, 8'h00, ack); chk("wr_ack_dev", 32'(ack), 32'h0);
    write_byte(8'h12, 8'h00, ack); chk("wr_ack_ah",  32'(ack), 32'h0);
    write_byte(8'h34, 8'h00, ack); chk("wr_ack_al",  32'(ack), 32'h0);
    write_byte(8'hA5, 8'h00, ack); chk("wr_ack_d",   32'(ack), 32'h0);
    chk("wr_busy_hi", 32'(busy), 32'h1);
    i2c_stop();
    chk("wr_busy_lo", 32'(busy), 32'h0);
    chk("wr_we_cnt",  32'(we_addr.size() - wb), 32'd1);
    chk("wr_we_addr", 32'(we_addr[wb]), 32'h1234);
    chk("wr_we_data", 32'(we_data[wb]), 32'hA5);

    // Combined write-address / repeated-START read
    bank[16'h1234] = 8'h5A;
    rb = re_addr.size();
    i2c_start();
    write_byte(8'h56, 8'h00, ack);
    write_byte(8'h12, 8'h00, ack);
    write_byte(8'h34, 8'h00, ack);
    i2c_rstart();
    write_byte(8'h57, 8'h00, ack); chk("rd_ack_dev", 32'(ack), 32'h0);
    read_byte(1'b1, d);
    chk("rd_data",    32'(d), 32'h5A);
    chk("rd_release", 32'(sda_out_en), 32'h0);
    i2c_stop();
    chk("rd_re_cnt",  32'(re_addr.size() - rb), 32'd1);
    chk("rd_re_addr", 32'(re_addr[rb]), 32'h1234);

    // Address mismatch
    ob = oe_cycles; wb = we_addr.size(); rb = re_addr.size();
    i2c_start();
    write_byte(8'h58, 8'h00, ack); chk("mm_nack", 32'(ack), 32'h1);
    write_byte(8'h00, 8'h00, ack);
    chk("mm_busy", 32'(busy), 32'h0);
    i2c_stop();
    chk("mm_oe",      32'(oe_cycles - ob), 32'd0);
    chk("mm_strobes", 32'((we_addr.size() - wb) + (re_addr.size() - rb)), 32'd0);

    // Burst write across the 16-bit wrap
    exp_wa = '{16'hFFFF, 16'h0000, 16'h0001};
    exp_wd = '{8'h01, 8'h02, 8'h03};
    wb = we_addr.size();
    i2c_start();
    write_byte(8'h56, 8'h00, ack);
    write_byte(8'hFF, 8'h00, ack);
    write_byte(8'hFF, 8'h00, ack);
    for (int i = 0; i < 3; i++) write_byte(exp_wd[i], 8'h00, ack);
    i2c_stop();
    chk("bw_cnt", 32'(we_addr.size() - wb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bw_addr%0d", i), 32'(we_addr[wb + i]), 32'(exp_wa[i]));
      chk($sformatf("bw_data%0d", i), 32'(we_data[wb + i]), 32'(exp_wd[i]));
    end

    // Burst read: ACK, ACK, NACK
    exp_ra = '{16'h0010, 16'h0011, 16'h0012};
    exp_rd = '{8'h81, 8'h00, 8'hC3};
    for (int i = 0; i < 3; i++) bank[exp_ra[i]] = exp_rd[i];
    rb = re_addr.size();
    i2c_start();
    write_byte(8'h56, 8'h00, ack);
    write_byte(8'h00, 8'h00, ack);
    write_byte(8'h10, 8'h00, ack);
    i2c_rstart();
    write_byte(8'h57, 8'h00, ack);
    for (int i = 0; i < 3; i++) begin
      read_byte(i == 2, d);
      chk($sformatf("br_data%0d", i), 32'(d), 32'(exp_rd[i]));
    end
    i2c_stop();
    wait_clk(20);
    chk("br_re_cnt", 32'(re_addr.size() - rb), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("br_re_addr%0d", i), 32'(re_addr[rb + i]), 32'(exp_ra[i]));

    // SDA glitches while SCL high (fake START on a 1 bit, fake STOP on a 0 bit)
    wb = we_addr.size();
    i2c_start();
    write_byte(8'h56, 8'h00, ack);
    write_byte(8'h01, 8'h00, ack);
    write_byte(8'h00, 8'h00, ack);
    write_byte(8'h3C, 8'hA0, ack); chk("gl_ack", 32'(ack), 32'h0);
    i2c_stop();
    chk("gl_cnt",  32'(we_addr.size() - wb), 32'd1);
    chk("gl_addr", 32'(we_addr[wb]), 32'h0100);
    chk("gl_data", 32'(we_data[wb]), 32'h3C);

    // Reset in the middle of a read byte whose bits are all zero
    bank[16'h0020] = 8'h00;
    i2c_start();
    write_byte(8'h56, 8'h00, ack);
    write_byte(8'h00, 8'h00, ack);
    write_byte(8'h20, 8'h00, ack);
    i2c_rstart();
    write_byte(8'h57, 8'h00, ack);
    for (int i = 0; i < 4; i++) clock_bit(s);
    chk("rs_oe_before", 32'(sda_out_en), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rs_oe_after", 32'(sda_out_en), 32'h0);
    wait_clk(3);
    rst = 1'b0;
    wb = we_addr.size(); rb = re_addr.size();
    chk("rs_addr", 32'(reg_addr), 32'h0);
    chk("rs_busy", 32'(busy), 32'h0);
    i2c_stop();
    chk("rs_strobes", 32'((we_addr.size() - wb) + (re_addr.size() - rb)), 32'd0);
    i2c_start();
    write_byte(8'h56, 8'h00, ack);
    write_byte(8'h00, 8'h00, ack);
    write_byte(8'h30, 8'h00, ack);
    write_byte(8'h77, 8'h00, ack); chk("rs_wr_ack", 32'(ack), 32'h0);
    i2c_stop();
    chk("rs_wr_cnt",  32'(we_addr.size() - wb), 32'd1);
    chk("rs_wr_addr", 32'(we_addr[wb]), 32'h0030);
    chk("rs_wr_data", 32'(we_data[wb]), 32'h77);
    chk("we_re_overlap", 32'(both_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
